// File: rtl/timer.sv
// Three-digit BCD countdown timer (M:ST:SO, 0:00..9:59) with keypad shift-in load,
// synchronous clear and a combinational zero flag.
module timer (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] data_in,
    input  logic       loadn,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       zero
);

    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] mins_q, mins_d;
    logic       load_ok;

    assign zero = (mins_q == 4'd0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);

    // Rejecting the shift when sec_ones>5 keeps sec_tens a valid 0-5 digit.
    assign load_ok = (data_in <= 4'd9) && (sec_ones_q <= 4'd5);

    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        mins_d     = mins_q;
        if (clear) begin
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            mins_d     = 4'd0;
        end else if (!loadn) begin
            if (load_ok) begin
                mins_d     = sec_tens_q;
                sec_tens_d = sec_ones_q;
                sec_ones_d = data_in;
            end
        end else if (enable && !zero) begin
            if (sec_ones_q != 4'd0) begin
                sec_ones_d = sec_ones_q - 4'd1;
            end else begin
                sec_ones_d = 4'd9;
                if (sec_tens_q != 4'd0) begin
                    sec_tens_d = sec_tens_q - 4'd1;
                end else begin
                    sec_tens_d = 4'd5;
                    mins_d     = mins_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            mins_q     <= 4'd0;
        end else begin
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            mins_q     <= mins_d;
        end
    end

    assign sec_ones = sec_ones_q;
    assign sec_tens = sec_tens_q;
    assign mins     = mins_q;

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for timer: stimulus pushes expected M:ST:SO per edge, a monitor
// pops and compares one entry after every rising edge.
module tb_timer;

    logic       clock;
    logic       resetn;
    logic [3:0] data_in;
    logic       loadn;
    logic       clear;
    logic       enable;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic       zero;

    typedef struct {
        string      name;
        logic [11:0] t;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    timer dut (
        .clock    (clock),
        .resetn   (resetn),
        .data_in  (data_in),
        .loadn    (loadn),
        .clear    (clear),
        .enable   (enable),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .mins     (mins),
        .zero     (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compares {mins, sec_tens, sec_ones, zero}; zero expectation derived from the digits.
    task automatic check(input string name, input logic [11:0] exp);
        logic [12:0] got;
        logic [12:0] want;
        got  = {mins, sec_tens, sec_ones, zero};
        want = {exp, (exp == 12'h000)};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h:%0h%0h zero=%0b, expected %0h:%0h%0h zero=%0b", name,
                     got[12:9], got[8:5], got[4:1], got[0],
                     want[12:9], want[8:5], want[4:1], want[0]);
        end
    endtask

    // Monitor: each rising edge presents a new state.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, e.t);
        end
    end

    task automatic step(input string name, input logic c, input logic ln, input logic en,
                        input logic [3:0] d, input logic [11:0] exp);
        exp_t e;
        @(negedge clock);
        clear   = c;
        loadn   = ln;
        enable  = en;
        data_in = d;
        e.name  = name;
        e.t     = exp;
        exp_q.push_back(e);
    endtask

    task automatic load(input string name, input logic [3:0] d, input logic [11:0] exp);
        step(name, 1'b0, 1'b0, 1'b0, d, exp);
    endtask

    task automatic count(input string name, input logic [11:0] exp);
        step(name, 1'b0, 1'b1, 1'b1, 4'd0, exp);
    endtask

    task automatic idle(input string name, input logic [11:0] exp);
        step(name, 1'b0, 1'b1, 1'b0, 4'd0, exp);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn  = 1'b0;
        clear   = 1'b0;
        loadn   = 1'b1;
        enable  = 1'b1;
        data_in = 4'd3;
        #2;
        check("reset_state", 12'h000);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        enable = 1'b0;

        // Load single digit then count to zero and hold.
        load("load5", 4'd5, 12'h005);
        count("cnt4", 12'h004);
        count("cnt3", 12'h003);
        count("cnt2", 12'h002);
        count("cnt1", 12'h001);
        count("cnt0", 12'h000);
        count("hold0_a", 12'h000);
        count("hold0_b", 12'h000);

        // Multi-digit load, then borrow from tens.
        load("ld_1", 4'd1, 12'h001);
        load("ld_13", 4'd3, 12'h013);
        load("ld_130", 4'd0, 12'h130);
        count("cnt_129", 12'h129);

        // Asynchronous reset mid-count; inputs ignored while held.
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset", 12'h000);
        step("reset_ignores_load", 1'b0, 1'b0, 1'b1, 4'd7, 12'h000);
        @(negedge clock);
        resetn = 1'b1;
        loadn  = 1'b1;
        enable = 1'b0;

        load("ld_1b", 4'd1, 12'h001);
        load("ld_10", 4'd0, 12'h010);
        load("ld_100", 4'd0, 12'h100);
        count("borrow_059", 12'h059);
        count("cnt_058", 12'h058);

        // Largest loadable value and its countdown.
        step("clr_a", 1'b1, 1'b1, 1'b0, 4'd0, 12'h000);
        load("ld_5", 4'd5, 12'h005);
        load("ld_55", 4'd5, 12'h055);
        load("ld_559", 4'd9, 12'h559);
        count("cnt_558", 12'h558);

        // Invalid loads hold.
        step("clr_b", 1'b1, 1'b1, 1'b0, 4'd0, 12'h000);
        load("ld_7", 4'd7, 12'h007);
        load("bad_digit", 4'hC, 12'h007);
        load("so_gt5", 4'd2, 12'h007);

        // Clear and priority.
        step("clr_c", 1'b1, 1'b1, 1'b0, 4'd0, 12'h000);
        load("ld_3", 4'd3, 12'h003);
        step("clr_over_en", 1'b1, 1'b1, 1'b1, 4'd0, 12'h000);
        load("ld_4", 4'd4, 12'h004);
        step("clr_over_ld", 1'b1, 1'b0, 1'b0, 4'd2, 12'h000);
        load("ld_2", 4'd2, 12'h002);
        step("ld_over_en", 1'b0, 1'b0, 1'b1, 4'd1, 12'h021);

        // Hold with enable low.
        step("clr_d", 1'b1, 1'b1, 1'b0, 4'd0, 12'h000);
        load("ld_4b", 4'd4, 12'h004);
        load("ld_45", 4'd5, 12'h045);
        for (int i = 0; i < 5; i++) idle("hold_045", 12'h045);
        count("cnt_044", 12'h044);

        @(negedge clock);
        loadn  = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 The timer SHALL have no parameters; the counter is fixed at three BCD digits, M:ST:SO, range 0:00 to 9:59.
REQ-002 The timer SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clock  input  1  Rising-edge clock; each rising edge is one count tick (one second in the system).
REQ-004 resetn  input  1  Asynchronous active-low reset.
REQ-005 data_in  input  4  BCD keypad digit to be shifted in.
REQ-006 loadn  input  1  Active-low load strobe; while low, each rising edge shifts data_in into the display.
REQ-007 clear  input  1  Synchronous active-high clear of all digits.
REQ-008 enable  input  1  Active-high count-down enable.
REQ-009 sec_ones  output  4  BCD seconds units, 0-9.
REQ-010 sec_tens  output  4  BCD seconds tens, 0-5.
REQ-011 mins  output  4  BCD minutes, 0-9.
REQ-012 zero  output  1  Combinational; 1 when mins, sec_tens and sec_ones are all 0.

Function
REQ-013 On each rising edge, exactly one action SHALL occur, in this priority order: clear, then load (loadn=0), then count (enable=1), then hold.
REQ-014 clear=1 SHALL set all three digits to 0 on the next rising edge, regardless of loadn and enable.
REQ-015 A load with data_in<=9 SHALL shift left in one edge: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=data_in.
REQ-016 A load with data_in>9 SHALL be ignored, and the digits SHALL hold.
REQ-017 A load where the current sec_ones>5 SHALL be ignored, and the digits SHALL hold, so that sec_tens never exceeds 5.
REQ-018 The old mins value SHALL be discarded on a shift.
REQ-019 Holding loadn low for N edges SHALL shift N times, one shift per edge, with no edge detection on loadn.
REQ-020 A count with zero=0 SHALL decrement the time by one second, as follows:
- sec_ones>0: decrement sec_ones.
- Otherwise, sec_ones<=9 and sec_tens borrows.
- sec_tens>0: decrement sec_tens.
- Otherwise, sec_tens<=5 and mins decrements.
REQ-021 A count with zero=1 SHALL hold at 0:00, with no wrap-around.
REQ-022 Count latency: outputs SHALL change on the same rising edge that samples enable=1.
REQ-023 When loadn=1, enable=0 and clear=0, all digits SHALL hold their value.
REQ-024 Digits SHALL be registered, and outputs SHALL be driven directly from the registers; zero is the only combinational output.

Reset
REQ-025 While resetn=0, sec_ones, sec_tens and mins SHALL be 0 immediately, independent of clock, and zero SHALL be 1.
REQ-026 While resetn=0, all inputs SHALL be ignored.
REQ-027 Deassertion of resetn SHALL take effect for the next rising edge.
REQ-028 resetn SHALL override any in-progress load or count.

Verification
REQ-029 Reset scenario: resetn=0 mid-count at 1:29 -> outputs 0:00 and zero=1 immediately, without waiting for a clock edge.
REQ-030 Load-and-count scenario: reset, then loadn=0 with data_in=5 for 1 edge, then loadn=1, enable=1 -> 0:05, 0:04, 0:03, 0:02, 0:01, 0:00, and 0:00 holds with zero=1 on later edges.
REQ-031 Multi-digit load and borrow scenario:
- Load 1,3,0 with enable=0 -> 1:30.
- Set enable=1 -> next edge gives 1:29.
- Load 1,0,0 and count -> 1:00 becomes 0:59.
REQ-032 Invalid-load scenario: from 0:07, load data_in=4'hC -> holds 0:07; then load data_in=2 -> holds 0:07 (sec_ones=7>5).
REQ-033 Clear and priority scenario:
- clear=1 for one edge at 0:03 with enable=1 -> 0:00.
- clear=1 with loadn=0 -> 0:00.
- loadn=0 with enable=1 -> shift, no decrement.
REQ-034 Hold scenario: enable=0 for 5 edges at 0:45 -> stays 0:45.
